// File: rtl/canright_sbox_word_engine.sv
// AES S-box (forward/inverse) applied bytewise to a word, BYTES_PER_CYCLE lanes
// time-multiplexed over the word, with optional first-order Boolean masking.
module canright_sbox_word_engine #(
  parameter int N_BYTES         = 4,
  parameter int BYTES_PER_CYCLE = 1,
  parameter bit MASKED          = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*N_BYTES-1:0] in_data,
  input  logic [8*N_BYTES-1:0] in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_BYTES-1:0] out_data,
  output logic [8*N_BYTES-1:0] out_mask,
  output logic                 busy,
  output logic [1:0]           fsm_state
);

  localparam int W  = 8 * N_BYTES;
  localparam int G  = N_BYTES / BYTES_PER_CYCLE;
  localparam int LW = 8 * BYTES_PER_CYCLE;
  localparam int CW = (G > 1) ? $clog2(G) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(G - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (N_BYTES < 1 || BYTES_PER_CYCLE < 1 || (N_BYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("canright_sbox_word_engine: BYTES_PER_CYCLE must divide N_BYTES");
    end
  endgenerate

  // GF(2^8) arithmetic in the AES polynomial basis (x^8+x^4+x^3+x+1).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // Two-share product: {z1,z0} with z0^z1 = (a0^a1)*(b0^b1); shares never recombined.
  function automatic logic [15:0] sh_mul(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] z0;
    logic [7:0] z1;
    z0 = gf_mul(a0, b0) ^ gf_mul(a0, b1);
    z1 = gf_mul(a1, b0) ^ gf_mul(a1, b1);
    return {z1, z0};
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]};
  endfunction

  // Masked tower inversion: a^-1 = a^16 * N^-1 with norm N = a^17 in the GF(2^4)
  // subfield, inverted there as N^14. Output remasked onto the input mask m.
  function automatic logic [7:0] sbox_lane(input logic [7:0] d, input logic [7:0] m,
                                           input logic inv);
    logic [7:0]  a0, a1, c0, c1;
    logic [7:0]  n2_0, n2_1, n4_0, n4_1, n8_0, n8_1;
    logic [15:0] nrm, t, u, r;
    logic [7:0]  res;
    if (inv) begin
      a0 = aff_inv(d) ^ 8'h05;
      a1 = aff_inv(m);
    end else begin
      a0 = d;
      a1 = m;
    end
    c0 = a0;
    c1 = a1;
    for (int i = 0; i < 4; i++) begin
      c0 = gf_sq(c0);
      c1 = gf_sq(c1);
    end
    nrm  = sh_mul(c0, c1, a0, a1);
    n2_0 = gf_sq(nrm[7:0]);
    n2_1 = gf_sq(nrm[15:8]);
    n4_0 = gf_sq(n2_0);
    n4_1 = gf_sq(n2_1);
    n8_0 = gf_sq(n4_0);
    n8_1 = gf_sq(n4_1);
    t    = sh_mul(n2_0, n2_1, n4_0, n4_1);
    u    = sh_mul(t[7:0], t[15:8], n8_0, n8_1);
    r    = sh_mul(c0, c1, u[7:0], u[15:8]);
    if (inv) res = r[7:0] ^ (r[15:8] ^ m);
    else     res = aff_fwd(r[7:0]) ^ 8'h63 ^ (aff_fwd(r[15:8]) ^ m);
    return res;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] grp;
  logic          inv_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  mask_q;
  logic [LW-1:0] grp_data;
  logic [LW-1:0] grp_mask;
  logic [LW-1:0] lane_res;

  always_comb begin
    grp_data = '0;
    grp_mask = '0;
    for (int g = 0; g < G; g++) begin
      if (grp == CW'(g)) begin
        grp_data = data_q[g*LW +: LW];
        grp_mask = mask_q[g*LW +: LW];
      end
    end
  end

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign lane_res[8*l +: 8] = sbox_lane(grp_data[8*l +: 8], grp_mask[8*l +: 8], inv_q);
  end

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so neither side ever overlaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grp      <= '0;
      inv_q    <= 1'b0;
      data_q   <= '0;
      mask_q   <= '0;
      out_data <= '0;
      out_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            mask_q <= MASKED ? in_mask : '0;
            inv_q  <= in_inv;
            grp    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int g = 0; g < G; g++) begin
            if (grp == CW'(g)) begin
              out_data[g*LW +: LW] <= lane_res;
              out_mask[g*LW +: LW] <= grp_mask;
            end
          end
          if (grp == LAST_GRP) state <= DONE;
          else                 grp   <= grp + 1'b1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_canright_sbox_word_engine.sv
// Bench for canright_sbox_word_engine: four configurations driven in lockstep
// (masked BPC=1, unmasked BPC=1/2/4) and checked against the FIPS-197 table.
module tb_canright_sbox_word_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_inv;
  logic        out_ready;
  logic [31:0] in_data_m;
  logic [31:0] in_data_u;
  logic [31:0] in_mask;
  logic [31:0] od [4];
  logic [31:0] om [4];
  logic        ir [4];
  logic        ov [4];
  logic        bz [4];
  logic [1:0]  st [4];

  int total = 0;
  int bad   = 0;
  int lat_exp [4] = '{4, 4, 2, 1};

  logic [31:0] exp_q[$];
  logic [31:0] exp_mask_q[$];

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] isbox_t [256];

  canright_sbox_word_engine #(.N_BYTES(4), .BYTES_PER_CYCLE(1), .MASKED(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_inv(in_inv),
    .in_data(in_data_m), .in_mask(in_mask), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_mask(om[0]), .busy(bz[0]), .fsm_state(st[0]));

  canright_sbox_word_engine #(.N_BYTES(4), .BYTES_PER_CYCLE(1), .MASKED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_inv(in_inv),
    .in_data(in_data_u), .in_mask(in_mask), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_mask(om[1]), .busy(bz[1]), .fsm_state(st[1]));

  canright_sbox_word_engine #(.N_BYTES(4), .BYTES_PER_CYCLE(2), .MASKED(1'b0)) dut_b2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_inv(in_inv),
    .in_data(in_data_u), .in_mask(in_mask), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_mask(om[2]), .busy(bz[2]), .fsm_state(st[2]));

  canright_sbox_word_engine #(.N_BYTES(4), .BYTES_PER_CYCLE(4), .MASKED(1'b0)) dut_b4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_inv(in_inv),
    .in_data(in_data_u), .in_mask(in_mask), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od[3]), .out_mask(om[3]), .busy(bz[3]), .fsm_state(st[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] x, input logic inv);
    logic [31:0] r;
    for (int j = 0; j < 4; j++)
      r[8*j +: 8] = inv ? isbox_t[x[8*j +: 8]] : sbox_t[x[8*j +: 8]];
    return r;
  endfunction

  // Drive one word to all engines; accept happens on the edge this task waits for.
  task automatic send(input logic [31:0] x, input logic [31:0] m, input logic inv, input bit push);
    int n;
    n = 0;
    while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", {28'd0, ir[0], ir[1], ir[2], ir[3]}, 32'hF);
    in_data_m = x ^ m;
    in_data_u = x;
    in_mask   = m;
    in_inv    = inv;
    in_valid  = 1'b1;
    if (push) begin
      exp_q.push_back(ref_word(x, inv));
      exp_mask_q.push_back(m);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Must follow send() with no edge in between: latency is counted from the accept edge.
  task automatic collect(input int hold);
    int          lat [4];
    logic [31:0] e;
    logic [31:0] em;
    logic [31:0] snap [4];
    lat = '{0, 0, 0, 0};
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (ov[i] && lat[i] == 0) lat[i] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("latency%0d", i), lat[i], lat_exp[i]);
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    em = (exp_mask_q.size() > 0) ? exp_mask_q.pop_front() : 'x;
    chk("data_masked", od[0] ^ om[0], e);
    chk("mask_masked", om[0], em);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("data%0d", i), od[i], e);
      chk($sformatf("mask%0d", i), om[i], 32'h0);
    end
    for (int i = 0; i < 4; i++) snap[i] = od[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("hold_data%0d", i), od[i], snap[i]);
        chk($sformatf("hold_flags%0d", i), {29'd0, ir[i], ov[i], bz[i]}, 32'h3);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("release%0d", i), {29'd0, ir[i], ov[i], bz[i]}, 32'h4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] m;
    logic [31:0] x2;
    logic [31:0] m2;
    logic        seen;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    // T1: reset with in_valid held high
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data_m = 32'hDEADBEEF;
    in_data_u = 32'h12345678;
    in_mask   = 32'hA5A5A5A5;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_flags%0d", i), {29'd0, ir[i], ov[i], bz[i]}, 32'h4);
      chk($sformatf("rst_data%0d", i), od[i], 32'h0);
      chk($sformatf("rst_mask%0d", i), om[i], 32'h0);
      chk($sformatf("rst_state%0d", i), {30'd0, st[i]}, 32'h0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst_busy%0d", i), {31'd0, bz[i]}, 32'h0);

    // T2/T3/T4 directed words
    send(32'hFF530100, 32'h0, 1'b0, 1'b1);
    collect(0);
    chk("t2_known", od[1], 32'h16ED7C63);
    send(32'h16ED7C63, 32'h0, 1'b1, 1'b1);
    collect(0);
    chk("t3_known", od[1], 32'hFF530100);
    send(32'hFF530100, 32'h15371342, 1'b0, 1'b1);
    collect(0);
    chk("t4_known_mask", om[0], 32'h15371342);
    chk("t4_known_data", od[0] ^ om[0], 32'h16ED7C63);

    // Exhaustive sweeps, forward and inverse, random masks
    for (int inv = 0; inv < 2; inv++) begin
      for (int v = 0; v < 256; v += 4) begin
        x = {8'(v + 3), 8'(v + 2), 8'(v + 1), 8'(v)};
        m = $urandom;
        send(x, m, inv[0], 1'b1);
        collect(0);
      end
    end
    for (int k = 0; k < 40; k++) begin
      x = $urandom;
      m = $urandom;
      send(x, m, 1'($urandom_range(0, 1)), 1'b1);
      collect(0);
    end

    // T5: backpressure with in_valid held high
    x  = $urandom;
    m  = $urandom;
    x2 = $urandom;
    m2 = $urandom;
    send(x, m, 1'b0, 1'b1);
    in_data_m = x2 ^ m2;
    in_data_u = x2;
    in_mask   = m2;
    in_inv    = 1'b1;
    in_valid  = 1'b1;
    collect(5);
    send(x2, m2, 1'b1, 1'b1);
    collect(0);

    // T6: reset one cycle into RUN; the word is dropped
    send(32'hCAFEF00D, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk($sformatf("t6_run_valid%0d", i), {31'd0, ov[i]}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_flags%0d", i), {29'd0, ir[i], ov[i], bz[i]}, 32'h4);
      chk($sformatf("t6_data%0d", i), od[i], 32'h0);
    end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) seen = seen | ov[i];
    end
    chk("t6_no_valid", {31'd0, seen}, 32'h0);
    send(32'h00000053, $urandom, 1'b0, 1'b1);
    collect(0);
    chk("t6_byte0_u", {24'd0, od[1][7:0]}, 32'hED);
    chk("t6_byte0_m", {24'd0, od[0][7:0] ^ om[0][7:0]}, 32'hED);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
